// File: rtl/rf_writeback_pkg.sv
// Shared constants and types for the register-file writeback block.
package rf_writeback_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned FIFO_PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    function automatic src_e other_src(input src_e s);
        return (s == SRC_ALU) ? SRC_MEM : SRC_ALU;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO holding {rd, data} entries for one writeback source.
module wb_fifo
    import rf_writeback_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_data,
    input  logic                  i_pop,
    output logic [WIDTH-1:0]      o_head,
    output logic [FIFO_CNT_W-1:0] o_count,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam logic [FIFO_CNT_W-1:0] FULL_CNT = FIFO_CNT_W'(FIFO_DEPTH);
    localparam logic [FIFO_CNT_W-1:0] CNT_ONE  = FIFO_CNT_W'(1);
    localparam logic [FIFO_PTR_W-1:0] PTR_ONE  = FIFO_PTR_W'(1);

    logic [WIDTH-1:0]      r_mem [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] r_wptr;
    logic [FIFO_PTR_W-1:0] r_rptr;
    logic [FIFO_CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    // A push into a full FIFO is dropped even if a pop happens on the same edge.
    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/rf_writeback.sv
// Merges ALU and load results into the single register-file write port,
// with round-robin arbitration, x0 suppression and same-cycle read bypass.
module rf_writeback
    import rf_writeback_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_alu_valid,
    output logic                  o_alu_ready,
    input  logic [REG_ADDR_W-1:0] i_alu_rd,
    input  logic [WIDTH-1:0]      i_alu_data,
    input  logic                  i_mem_valid,
    output logic                  o_mem_ready,
    input  logic [REG_ADDR_W-1:0] i_mem_rd,
    input  logic [WIDTH-1:0]      i_mem_data,
    output logic [REG_ADDR_W-1:0] o_a3,
    output logic [WIDTH-1:0]      o_wd3,
    output logic                  o_we3,
    input  logic [REG_ADDR_W-1:0] i_byp_a1,
    input  logic [REG_ADDR_W-1:0] i_byp_a2,
    output logic                  o_byp_hit1,
    output logic                  o_byp_hit2,
    output logic [WIDTH-1:0]      o_byp_data1,
    output logic [WIDTH-1:0]      o_byp_data2
);

    localparam int unsigned ENTRY_W = REG_ADDR_W + WIDTH;
    localparam logic [FIFO_CNT_W-1:0] FULL_CNT = FIFO_CNT_W'(FIFO_DEPTH);

    logic                  r_live;
    src_e                  r_last_gnt;
    src_e                  w_pref;

    logic [ENTRY_W-1:0]    w_alu_entry;
    logic [ENTRY_W-1:0]    w_mem_entry;
    logic [ENTRY_W-1:0]    w_alu_head;
    logic [ENTRY_W-1:0]    w_mem_head;
    logic [ENTRY_W-1:0]    w_head;
    logic [FIFO_CNT_W-1:0] w_alu_count;
    logic [FIFO_CNT_W-1:0] w_mem_count;
    logic                  w_alu_full;
    logic                  w_mem_full;
    logic                  w_alu_empty;
    logic                  w_mem_empty;
    logic                  w_alu_push;
    logic                  w_mem_push;
    logic                  w_gnt_alu;
    logic                  w_gnt_mem;
    logic                  w_gnt;
    logic [REG_ADDR_W-1:0] w_head_rd;
    logic [WIDTH-1:0]      w_head_data;

    // Readies stay low through reset and rise on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    assign o_alu_ready = r_live & ~w_alu_full;
    assign o_mem_ready = r_live & ~w_mem_full;

    assign w_alu_push  = i_alu_valid & o_alu_ready;
    assign w_mem_push  = i_mem_valid & o_mem_ready;
    assign w_alu_entry = {i_alu_rd, i_alu_data};
    assign w_mem_entry = {i_mem_rd, i_mem_data};

    wb_fifo #(
        .WIDTH (ENTRY_W)
    ) u_alu_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_alu_push),
        .i_data  (w_alu_entry),
        .i_pop   (w_gnt_alu),
        .o_head  (w_alu_head),
        .o_count (w_alu_count),
        .o_full  (w_alu_full),
        .o_empty (w_alu_empty)
    );

    wb_fifo #(
        .WIDTH (ENTRY_W)
    ) u_mem_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_mem_push),
        .i_data  (w_mem_entry),
        .i_pop   (w_gnt_mem),
        .o_head  (w_mem_head),
        .o_count (w_mem_count),
        .o_full  (w_mem_full),
        .o_empty (w_mem_empty)
    );

    assign w_pref = other_src(r_last_gnt);

    always_comb begin
        w_gnt_alu = 1'b0;
        w_gnt_mem = 1'b0;
        if (!w_alu_empty && !w_mem_empty) begin
            if (w_pref == SRC_ALU) begin
                w_gnt_alu = 1'b1;
            end else begin
                w_gnt_mem = 1'b1;
            end
        end else if (!w_alu_empty) begin
            w_gnt_alu = 1'b1;
        end else if (!w_mem_empty) begin
            w_gnt_mem = 1'b1;
        end
    end

    assign w_gnt = w_gnt_alu | w_gnt_mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_gnt <= SRC_MEM;
        end else if (w_gnt_alu) begin
            r_last_gnt <= SRC_ALU;
        end else if (w_gnt_mem) begin
            r_last_gnt <= SRC_MEM;
        end
    end

    always_comb begin
        w_head = '0;
        if (w_gnt_alu) begin
            w_head = w_alu_head;
        end else if (w_gnt_mem) begin
            w_head = w_mem_head;
        end
    end

    assign w_head_rd   = w_head[ENTRY_W-1 -: REG_ADDR_W];
    assign w_head_data = w_head[WIDTH-1:0];

    // x0 entries still pop; only the write enable is suppressed.
    assign o_a3  = w_head_rd;
    assign o_wd3 = w_head_data;
    assign o_we3 = w_gnt & (w_head_rd != '0);

    assign o_byp_hit1  = o_we3 & (o_a3 == i_byp_a1);
    assign o_byp_hit2  = o_we3 & (o_a3 == i_byp_a2);
    assign o_byp_data1 = o_byp_hit1 ? o_wd3 : '0;
    assign o_byp_data2 = o_byp_hit2 ? o_wd3 : '0;

    a_alu_full_cnt: assert property (@(posedge clk) disable iff (!rst_n)
        w_alu_full == (w_alu_count == FULL_CNT));
    a_mem_full_cnt: assert property (@(posedge clk) disable iff (!rst_n)
        w_mem_full == (w_mem_count == FULL_CNT));

endmodule

// File: tb/tb_rf_writeback.sv
// Directed self-checking bench for rf_writeback.
module tb_rf_writeback;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic        we3;
    logic [4:0]  byp_a1;
    logic [4:0]  byp_a2;
    logic        byp_hit1;
    logic        byp_hit2;
    logic [31:0] byp_data1;
    logic [31:0] byp_data2;

    int n_tests;
    int n_fail;

    rf_writeback #(
        .WIDTH (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_alu_valid (alu_valid),
        .o_alu_ready (alu_ready),
        .i_alu_rd    (alu_rd),
        .i_alu_data  (alu_data),
        .i_mem_valid (mem_valid),
        .o_mem_ready (mem_ready),
        .i_mem_rd    (mem_rd),
        .i_mem_data  (mem_data),
        .o_a3        (a3),
        .o_wd3       (wd3),
        .o_we3       (we3),
        .i_byp_a1    (byp_a1),
        .i_byp_a2    (byp_a2),
        .o_byp_hit1  (byp_hit1),
        .o_byp_hit2  (byp_hit2),
        .o_byp_data1 (byp_data1),
        .o_byp_data2 (byp_data2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Backpressure scenario expectations, one entry per cycle.
    logic [4:0]  bp_rd  [8] = '{5'd0, 5'd10, 5'd20, 5'd11, 5'd21, 5'd12, 5'd13, 5'd0};
    logic        bp_we  [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] bp_wd  [8] = '{32'h0, 32'hA0, 32'hB0, 32'hA1, 32'hB1, 32'hA2, 32'hA3, 32'h0};
    logic        bp_ard [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic        bp_mrd [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        int  ai;
        int  mi;
        logic acc_a;
        logic acc_m;

        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        alu_valid = 1'b0;
        alu_rd    = '0;
        alu_data  = '0;
        mem_valid = 1'b0;
        mem_rd    = '0;
        mem_data  = '0;
        byp_a1    = '0;
        byp_a2    = '0;

        // Reset state
        #12;
        check("rst_alu_ready", alu_ready, 0);
        check("rst_mem_ready", mem_ready, 0);
        check("rst_we3", we3, 0);
        check("rst_a3", a3, 0);
        check("rst_wd3", wd3, 0);
        check("rst_hit1", byp_hit1, 0);
        check("rst_hit2", byp_hit2, 0);
        rst_n = 1'b1;
        #1;
        check("rel_alu_ready_pre_edge", alu_ready, 0);
        tick();
        check("rel_alu_ready", alu_ready, 1);
        check("rel_mem_ready", mem_ready, 1);

        // Contention: ALU wins first after reset, then strict alternation
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
        mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'h22;
        tick();
        alu_rd = 5'd3; alu_data = 32'h33;
        mem_rd = 5'd4; mem_data = 32'h44;
        @(negedge clk);
        check("cont0_we3", we3, 1);
        check("cont0_a3", a3, 1);
        check("cont0_wd3", wd3, 32'h11);
        tick();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        @(negedge clk);
        check("cont1_a3", a3, 2);
        check("cont1_wd3", wd3, 32'h22);
        tick();
        @(negedge clk);
        check("cont2_a3", a3, 3);
        check("cont2_wd3", wd3, 32'h33);
        tick();
        @(negedge clk);
        check("cont3_a3", a3, 4);
        check("cont3_we3", we3, 1);
        tick();
        @(negedge clk);
        check("cont_idle_we3", we3, 0);

        // Single ALU write
        tick();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        tick();
        alu_valid = 1'b0;
        @(negedge clk);
        check("single_we3", we3, 1);
        check("single_a3", a3, 5);
        check("single_wd3", wd3, 32'hDEADBEEF);
        tick();
        @(negedge clk);
        check("single_after_we3", we3, 0);

        // Bypass
        tick();
        byp_a1 = 5'd7; byp_a2 = 5'd8;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h1234;
        tick();
        alu_valid = 1'b0;
        @(negedge clk);
        check("byp_hit1", byp_hit1, 1);
        check("byp_data1", byp_data1, 32'h1234);
        check("byp_hit2", byp_hit2, 0);
        check("byp_data2", byp_data2, 0);
        tick();
        @(negedge clk);
        check("byp_idle_hit1", byp_hit1, 0);

        // x0 drop, followed by a real write that proves the x0 entry popped
        tick();
        byp_a1 = 5'd0; byp_a2 = 5'd0;
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hFFFFFFFF;
        tick();
        mem_rd = 5'd9; mem_data = 32'h99;
        @(negedge clk);
        check("x0_we3", we3, 0);
        check("x0_hit1", byp_hit1, 0);
        check("x0_hit2", byp_hit2, 0);
        tick();
        mem_valid = 1'b0;
        @(negedge clk);
        check("x0_next_we3", we3, 1);
        check("x0_next_a3", a3, 9);
        tick();
        @(negedge clk);
        check("x0_idle_we3", we3, 0);

        // Backpressure: MEM valid for 3 cycles, ALU fed continuously
        tick();
        ai = 0;
        mi = 0;
        for (int c = 0; c < 8; c++) begin
            alu_valid = (ai < 4);
            alu_rd    = 5'(10 + ai);
            alu_data  = 32'(32'hA0 + ai);
            mem_valid = (c < 3);
            mem_rd    = 5'(20 + mi);
            mem_data  = 32'(32'hB0 + mi);
            @(negedge clk);
            check($sformatf("bp%0d_we3", c), we3, bp_we[c]);
            check($sformatf("bp%0d_a3", c), a3, bp_rd[c]);
            check($sformatf("bp%0d_wd3", c), wd3, bp_wd[c]);
            check($sformatf("bp%0d_alu_ready", c), alu_ready, bp_ard[c]);
            check($sformatf("bp%0d_mem_ready", c), mem_ready, bp_mrd[c]);
            acc_a = alu_valid & alu_ready;
            acc_m = mem_valid & mem_ready;
            tick();
            if (acc_a) ai++;
            if (acc_m) mi++;
        end
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        check("bp_alu_accepted", ai, 4);
        check("bp_mem_accepted", mi, 2);

        // Reset mid-stream with entries queued in both FIFOs
        byp_a1 = 5'd14; byp_a2 = 5'd15;
        alu_valid = 1'b1; alu_rd = 5'd14; alu_data = 32'hC0;
        mem_valid = 1'b1; mem_rd = 5'd15; mem_data = 32'hD0;
        tick();
        tick();
        tick();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        #1;
        check("mid_pre_we3", we3, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_we3", we3, 0);
        check("mid_rst_a3", a3, 0);
        check("mid_rst_wd3", wd3, 0);
        check("mid_rst_hit1", byp_hit1, 0);
        check("mid_rst_hit2", byp_hit2, 0);
        check("mid_rst_alu_ready", alu_ready, 0);
        check("mid_rst_mem_ready", mem_ready, 0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rel_alu_ready_pre", alu_ready, 0);
        check("mid_rel_we3_pre", we3, 0);
        tick();
        check("mid_rel_alu_ready", alu_ready, 1);
        check("mid_rel_mem_ready", mem_ready, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("mid_stale%0d_we3", k), we3, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
